// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP TX frame arbiter.
//   - arbiter state encoding (idle / pass / drain)
//   - default maximum UDP payload length
//   - rr_select(): round-robin one-hot pick over up to MaxSources requesters
package udp_arb_pkg;

   localparam int unsigned MaxSources    = 8;
   localparam int unsigned DefaultMaxLen = 1472;  // 1500 MTU - 20 IP - 8 UDP

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t StIdle  = 2'd0;
   localparam arb_state_t StPass  = 2'd1;
   localparam arb_state_t StDrain = 2'd2;

   // First set bit of req scanning ptr, ptr+1, ... modulo n; zero if none.
   function automatic logic [MaxSources-1:0] rr_select(input logic [MaxSources-1:0] req,
                                                       input logic [2:0]            ptr,
                                                       input int unsigned           n);
      logic [MaxSources-1:0] gnt;
      logic                  found;
      logic [2:0]            idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MaxSources; i++) begin
         idx = (n == 0) ? 3'd0 : 3'((32'(ptr) + i) % n);
         if (i < n && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage registered AXI-Stream slice carrying data/last/user.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid_i/in_ready_o   upstream handshake; in_ready_o = !valid || out_ready_i
//   in_data_i/last/user     upstream payload
//   out_valid_o/out_ready_i downstream handshake
//   out_data_o/last/user    registered payload, stable while stalled
module axis_pipe_reg #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_last_i,
   input  logic                  in_user_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  out_user_o,
   input  logic                  out_ready_i
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  user_q, user_d;
   logic                  load;

   assign in_ready_o = !valid_q || out_ready_i;
   assign load       = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      user_d  = user_q;
      if (load) begin
         // Covers the simultaneous drain+load case: valid stays high, new beat.
         valid_d = 1'b1;
         data_d  = in_data_i;
         last_d  = in_last_i;
         user_d  = in_user_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         user_q  <= user_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_last_o  = last_q;
   assign out_user_o  = user_q;

endmodule

// File: rtl/udp_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding the UDP TX payload FIFO.
// Grants are held until the source's tlast; frames longer than MAX_LEN are
// cut at MAX_LEN (forced tlast+tuser) and the remainder is drained and dropped.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   s_axis_*                   S_COUNT packed source streams (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*                   registered output stream, 1-cycle latency
//   status_grant               one-hot current grant, 0 when idle
//   status_truncated           one-cycle pulse per truncated frame
module udp_tx_frame_arb
   import udp_arb_pkg::*;
#(
   parameter int unsigned S_COUNT    = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_LEN    = DefaultMaxLen,
   parameter int unsigned LEN_WIDTH  = 11
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT-1:0]            s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic [S_COUNT-1:0]            status_grant,
   output logic                          status_truncated
);

   arb_state_t             state_q, state_d;
   logic [S_COUNT-1:0]     grant_q, grant_d;
   logic [2:0]             rr_ptr_q, rr_ptr_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   trunc_q, trunc_d;

   logic [S_COUNT-1:0]     sel_gnt;
   logic                   src_valid, src_last, src_user, src_ready;
   logic [DATA_WIDTH-1:0]  src_data;
   logic [2:0]             next_ptr;
   logic                   pipe_ready, load_valid, load_last, load_user;
   logic                   xfer, at_max;

   assign sel_gnt = S_COUNT'(rr_select(MaxSources'(s_axis_tvalid), rr_ptr_q, S_COUNT));

   // Mux the granted source and work out where the pointer goes after it.
   always_comb begin
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_user  = 1'b0;
      src_data  = '0;
      next_ptr  = rr_ptr_q;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
         if (grant_q[i]) begin
            src_valid = s_axis_tvalid[i];
            src_last  = s_axis_tlast[i];
            src_user  = s_axis_tuser[i];
            src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            next_ptr  = (i == S_COUNT - 1) ? 3'd0 : 3'(i + 1);
         end
      end
   end

   assign src_ready = (state_q == StPass)  ? pipe_ready :
                      (state_q == StDrain) ? 1'b1 : 1'b0;
   assign s_axis_tready = src_ready ? grant_q : '0;
   assign xfer          = src_valid && src_ready;

   // This beat is number MAX_LEN of the frame.
   assign at_max     = (cnt_q == LEN_WIDTH'(MAX_LEN - 1));
   assign load_valid = (state_q == StPass) && src_valid;
   assign load_last  = src_last || at_max;
   assign load_user  = src_user || (at_max && !src_last);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      trunc_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|s_axis_tvalid) begin
               grant_d = sel_gnt;
               cnt_d   = '0;
               state_d = StPass;
            end
         end
         StPass: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (src_last) begin
                  grant_d  = '0;
                  cnt_d    = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = StIdle;
               end else if (at_max) begin
                  trunc_d = 1'b1;
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (xfer && src_last) begin
               grant_d  = '0;
               cnt_d    = '0;
               rr_ptr_d = next_ptr;
               state_d  = StIdle;
            end
         end
         default: begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         trunc_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         trunc_q  <= trunc_d;
      end
   end

   axis_pipe_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (load_valid),
      .in_data_i   (src_data),
      .in_last_i   (load_last),
      .in_user_i   (load_user),
      .in_ready_o  (pipe_ready),
      .out_valid_o (m_axis_tvalid),
      .out_data_o  (m_axis_tdata),
      .out_last_o  (m_axis_tlast),
      .out_user_o  (m_axis_tuser),
      .out_ready_i (m_axis_tready)
   );

   assign status_grant     = grant_q;
   assign status_truncated = trunc_q;

endmodule

// File: tb/tb_udp_tx_frame_arb.sv
module tb_udp_tx_frame_arb;

   localparam int S  = 2;
   localparam int W  = 8;
   localparam int ML = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [S*W-1:0] s_tdata;
   logic [S-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
   logic [W-1:0]   m_tdata;
   logic           m_tvalid, m_tready, m_tlast, m_tuser;
   logic [S-1:0]   status_grant;
   logic           status_truncated;

   always #5 clk = ~clk;

   udp_tx_frame_arb #(
      .S_COUNT    (S),
      .DATA_WIDTH (W),
      .MAX_LEN    (ML),
      .LEN_WIDTH  (5)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_tdata     (s_tdata),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tready    (s_tready),
      .s_axis_tlast     (s_tlast),
      .s_axis_tuser     (s_tuser),
      .m_axis_tdata     (m_tdata),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .m_axis_tuser     (m_tuser),
      .status_grant     (status_grant),
      .status_truncated (status_truncated)
   );

   int checks = 0;
   int errors = 0;

   // Beat encoding: {user, last, data}
   logic [9:0] src_q [S][$];
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   int         got_cyc[$];
   int         model_ptr = 0;
   int         exp_trunc, trunc_seen;
   int         first_grant;
   logic [S-1:0] first_grant_val;

   task automatic add_frame(input int s, input int len, input logic user_last, input logic rnd);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
         src_q[s].push_back({(i == len - 1) ? user_last : 1'b0, (i == len - 1), d});
      end
   endtask

   // Frame-level reference: round-robin over sources with pending frames,
   // frames cut at ML beats with last+user forced on the cut beat.
   task automatic build_expected();
      logic [9:0] m [S][$];
      logic [9:0] b;
      int         n, s;
      logic       any;
      exp_q.delete();
      exp_trunc = 0;
      for (int k = 0; k < S; k++) m[k] = src_q[k];
      any = 1'b1;
      while (any) begin
         s = -1;
         for (int k = 0; k < S; k++)
            if (s < 0 && m[(model_ptr + k) % S].size() > 0) s = (model_ptr + k) % S;
         if (s < 0) begin
            any = 1'b0;
         end else begin
            n = 0;
            do begin
               b = m[s].pop_front();
               n++;
               if (n < ML) exp_q.push_back(b);
               else if (n == ML) begin
                  if (b[8]) exp_q.push_back(b);
                  else begin
                     exp_q.push_back({1'b1, 1'b1, b[7:0]});
                     exp_trunc++;
                  end
               end
            end while (!b[8]);
            model_ptr = (s + 1) % S;
         end
      end
   endtask

   // Drives all source queues, records output beats; rmode 0=ready, 1=1010, 2=random.
   task automatic run_traffic(input logic gaps, input int rmode, input int stop_after);
      int         cyc, acc_total;
      logic [S-1:0] in_frame, pend, acc;
      logic       stall_prev, done;
      logic [9:0] stall_beat, b;
      if (stop_after == 0) build_expected();
      got_q.delete();
      got_cyc.delete();
      trunc_seen  = 0;
      first_grant = -1;
      first_grant_val = '0;
      cyc = 0; acc_total = 0; in_frame = '0; pend = '0;
      stall_prev = 1'b0; stall_beat = '0; done = 1'b0;
      while (!done && cyc < 3000) begin
         for (int s = 0; s < S; s++) begin
            if (src_q[s].size() > 0 &&
                !(gaps && in_frame[s] && !pend[s] && $urandom_range(3) == 0)) begin
               b = src_q[s][0];
               s_tvalid[s] = 1'b1;
               s_tdata[s*W +: W] = b[7:0];
               s_tlast[s] = b[8];
               s_tuser[s] = b[9];
            end else begin
               s_tvalid[s] = 1'b0;
            end
         end
         m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
         @(negedge clk);
         if (first_grant < 0 && status_grant != '0) begin
            first_grant = cyc;
            first_grant_val = status_grant;
         end
         if (status_truncated) trunc_seen++;
         if (stall_prev) begin
            checks++;
            if (!m_tvalid || {m_tuser, m_tlast, m_tdata} !== stall_beat) begin
               errors++;
               $display("FAIL stall_hold cyc %0d got v=%b %h exp v=1 %h", cyc, m_tvalid,
                        {m_tuser, m_tlast, m_tdata}, stall_beat);
            end
         end
         stall_prev = m_tvalid && !m_tready;
         stall_beat = {m_tuser, m_tlast, m_tdata};
         if (m_tvalid && m_tready) begin
            got_q.push_back({m_tuser, m_tlast, m_tdata});
            got_cyc.push_back(cyc);
         end
         acc = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         for (int s = 0; s < S; s++) begin
            pend[s] = s_tvalid[s] && !acc[s];
            if (acc[s]) begin
               b = src_q[s].pop_front();
               in_frame[s] = !b[8];
               acc_total++;
            end
         end
         cyc++;
         if (stop_after > 0) done = (acc_total >= stop_after);
         else done = (src_q[0].size() == 0 && src_q[1].size() == 0 &&
                      got_q.size() >= exp_q.size());
      end
      if (stop_after == 0) begin
         s_tvalid = '0;
         m_tready = 1'b1;
         checks++;
         if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL beat_count got %0d exp %0d", got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (trunc_seen != exp_trunc) begin
            errors++;
            $display("FAIL trunc_pulses got %0d exp %0d", trunc_seen, exp_trunc);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, status_grant, status_truncated} !== '0)
      begin
         errors++;
         $display("FAIL %s got rdy=%b v=%b d=%h l=%b u=%b g=%b t=%b exp all 0", name, s_tready,
                  m_tvalid, m_tdata, m_tlast, m_tuser, status_grant, status_truncated);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_outputs");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_frame();
      add_frame(0, 4, 1'b0, 1'b0);
      run_traffic(1'b0, 0, 0);
      checks++;
      if (first_grant != 1 || first_grant_val !== 2'b01) begin
         errors++;
         $display("FAIL single_grant got cyc %0d val %b exp cyc 1 val 01", first_grant,
                  first_grant_val);
      end
      checks++;
      if (got_cyc.size() != 4 || got_cyc[0] != 2 || got_cyc[3] != 5) begin
         errors++;
         $display("FAIL single_timing got n=%0d first=%0d exp n=4 first=2 last=5",
                  got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1);
      end
      checks++;
      if (got_q.size() != 4 || got_q[3] !== 10'h144) begin
         errors++;
         $display("FAIL single_last_beat got %h exp 144", (got_q.size() > 3) ? got_q[3] : 10'h0);
      end
   endtask

   task automatic test_contention();
      for (int k = 0; k < 2; k++) begin
         add_frame(0, 3, 1'b0, 1'b1);
         add_frame(1, 3, 1'b0, 1'b1);
      end
      run_traffic(1'b0, 0, 0);
      for (int i = 1; i < got_cyc.size(); i++) begin
         checks++;
         if (got_cyc[i] - got_cyc[i-1] != (got_q[i-1][8] ? 2 : 1)) begin
            errors++;
            $display("FAIL contention_gap beat %0d got %0d exp %0d", i,
                     got_cyc[i] - got_cyc[i-1], got_q[i-1][8] ? 2 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      add_frame(0, 8, 1'b0, 1'b1);
      run_traffic(1'b0, 1, 0);
   endtask

   task automatic test_truncation();
      add_frame(1, 20, 1'b0, 1'b1);
      add_frame(1, 4, 1'b0, 1'b1);
      add_frame(0, 5, 1'b0, 1'b0);
      run_traffic(1'b0, 0, 0);
      checks++;
      if (got_q.size() < 21 || got_q[16] !== 10'h011 || got_q[15][9:8] !== 2'b11) begin
         errors++;
         $display("FAIL trunc_next_src got %h exp 011 after cut",
                  (got_q.size() > 16) ? got_q[16] : 10'h0);
      end
   endtask

   task automatic test_boundary();
      add_frame(0, ML, 1'b0, 1'b1);
      add_frame(1, ML, 1'b1, 1'b1);
      run_traffic(1'b0, 0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < S; s++)
            for (int f = 0; f < int'($urandom_range(1, 3)); f++)
               add_frame(s, $urandom_range(1, 22), 1'($urandom_range(1)), 1'b1);
         run_traffic(1'b1, 2, 0);
      end
   endtask

   task automatic test_reset_mid_frame();
      add_frame(0, 10, 1'b0, 1'b1);
      run_traffic(1'b0, 0, 3);
      checks++;
      if (m_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL midframe_active got %b exp 1", m_tvalid);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("midframe_reset_outputs");
      for (int s = 0; s < S; s++) src_q[s].delete();
      s_tvalid = '0;
      model_ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      add_frame(1, 10, 1'b0, 1'b1);
      run_traffic(1'b0, 0, 0);
   endtask

   initial begin
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      m_tready = 1'b1;
      test_reset();
      test_single_frame();
      test_contention();
      test_backpressure();
      test_truncation();
      test_boundary();
      test_random();
      test_reset_mid_frame();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_tx_frame_arb.md
Name: udp_tx_frame_arb

Overview:
- Frame-granular round-robin arbiter that shares the single 8-bit UDP TX payload stream between S_COUNT AXI-Stream sources, for example several partition outputs plus a status source.
- Sits between the source streams and the TX payload FIFO input.
- Holds each grant until the source's tlast.
- Enforces a maximum UDP payload length: an over-length frame is truncated and marked bad with tuser, and its remainder is drained and discarded.
- Output is registered: 1-cycle latency, full throughput.

Parameters:
- S_COUNT, 2, number of source streams (2..8).
- DATA_WIDTH, 8, tdata width per source.
- MAX_LEN, 1472, maximum payload bytes per frame (1500 MTU minus IP and UDP headers).
- LEN_WIDTH, 11, beat counter width; must satisfy 2**LEN_WIDTH > MAX_LEN.

Ports:
- clk  in  1  system clock (125 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed source data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  S_COUNT  per-source valid.
- s_axis_tready  out  S_COUNT  per-source ready.
- s_axis_tlast  in  S_COUNT  per-source end of frame.
- s_axis_tuser  in  S_COUNT  per-source bad-frame flag.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  1  output bad-frame flag.
- status_grant  out  S_COUNT  one-hot current grant; 0 when idle.
- status_truncated  out  1  single-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0: s_axis_tready, m_axis_tvalid/tdata/tlast/tuser, status_grant, status_truncated.
  - State is IDLE, rr_ptr = 0, beat count = 0.
- States:
  - IDLE
    - All s_axis_tready are 0.
    - If any s_axis_tvalid is set, select the first set index scanning rr_ptr, rr_ptr+1, ... modulo S_COUNT.
    - Register the grant (status_grant one-hot) and go to PASS next cycle.
    - Grant-to-first-accept latency is 1 cycle.
  - PASS
    - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready); all other readies are 0.
    - On each source transfer, load the output register with the source's tdata/tlast/tuser and increment the count.
    - Transfer with tlast=1: clear grant and count, set rr_ptr = (g+1) mod S_COUNT, go to IDLE.
    - Transfer that is beat number MAX_LEN with tlast=0:
      - Output beat is forced tlast=1 and tuser=1.
      - Pulse status_truncated.
      - Go to DRAIN.
    - Frame of exactly MAX_LEN beats ending in tlast: passes unmodified (tuser as supplied).
    - Source tvalid low mid-frame: bubble only; grant is held indefinitely.
  - DRAIN
    - s_axis_tready[g] = 1 unconditionally; beats are discarded and the output register is not loaded.
    - On a tlast transfer: clear grant and count, advance rr_ptr to (g+1) mod S_COUNT, go to IDLE.
- Output register:
  - m_axis_tvalid is set on load.
  - It clears when m_axis_tready=1 and no new load happens that cycle.
  - Simultaneous drain and load keeps tvalid at 1 with the new data.
  - Output data is held stable while tvalid=1 and tready=0.
- Throughput: 1 beat/cycle within a frame; exactly 1 idle arbitration cycle between frames.
- Fairness: after a frame from source g, source g has lowest priority.
- Reset mid-frame: the partial frame is abandoned and the output tvalid drops immediately. The downstream FIFO tolerates this (non-frame FIFO).
- status_grant stays high for the whole of PASS and DRAIN.

Decomposition:
- Shared package udp_arb_pkg:
  - state enum {IDLE, PASS, DRAIN}.
  - MAX_LEN default constant (1472).
  - Helper function rr_select(req, ptr) returning a one-hot grant.
- One sub-module: axis_pipe_reg, the single-stage registered AXIS slice (data/last/user) holding the output register and its ready logic.
- The arbiter FSM and counters stay in udp_tx_frame_arb.

Test Plan:
- Single frame: source 0 sends 4 bytes 0x11..0x44 with m_axis_tready=1.
  - status_grant=01 one cycle after tvalid.
  - Output shows 4 beats on consecutive cycles, tlast on 0x44, tuser=0.
- Contention: both sources hold 3-byte frames continuously.
  - Output order is src0, src1, src0, src1.
  - Exactly 1 idle cycle between frames; no interleaving within a frame.
- Backpressure: m_axis_tready toggles 1010... during an 8-byte frame.
  - All 8 bytes arrive in order with no duplicates or drops.
  - tdata is stable while stalled.
- Truncation: MAX_LEN=16, source 1 sends 20 bytes.
  - Output has 16 beats; beat 16 has tlast=1, tuser=1.
  - status_truncated pulses once.
  - The remaining 4 source beats are accepted and discarded.
  - Next grant goes to source 0.
- Boundary: MAX_LEN=16, frame of exactly 16 bytes with tlast on beat 16 -> passes with tuser=0 and no truncation pulse. Input tuser=1 on the last beat -> output tuser=1.
- Reset mid-frame: assert rst_n=0 after beat 3 of a 10-byte frame.
  - All outputs go to 0 asynchronously.
  - After release, a new frame from source 1 is granted first and passes intact.
